// File: rtl/estacionamiento_multicarril.sv
// estacionamiento_multicarril: N-lane two-sensor entry/exit detector with debounce and a shared saturating occupancy counter
module estacionamiento_multicarril #(
   parameter int N_LANES    = 2,
   parameter int CAPACITY   = 16,
   parameter int CNT_W      = 5,
   parameter int DEB_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_LANES-1:0] a,
   input  logic [N_LANES-1:0] b,
   input  logic               cargar,
   input  logic [CNT_W-1:0]   valor_carga,
   output logic [N_LANES-1:0] ingreso,
   output logic [N_LANES-1:0] egreso,
   output logic [N_LANES-1:0] error,
   output logic [CNT_W-1:0]   ocupacion,
   output logic               lleno,
   output logic               vacio
);
   localparam int RW = $clog2(DEB_CYCLES + 1);
   localparam logic [RW-1:0] DEB = RW'(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CAP_U = CNT_W'(CAPACITY);
   localparam logic signed [CNT_W+1:0] CAP_S = $signed((CNT_W+2)'(CAPACITY));
   localparam logic signed [CNT_W+1:0] ONE = $signed((CNT_W+2)'(1));
   localparam logic signed [CNT_W+1:0] ZERO = $signed((CNT_W+2)'(0));

   typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3} state_t;
   typedef struct packed {
      state_t st;
      logic   ing;
      logic   egr;
      logic   err;
   } paso_t;

   logic [1:0]              s1 [N_LANES];
   logic [1:0]              s2 [N_LANES];
   logic [1:0]              prv [N_LANES];
   logic [1:0]              stb [N_LANES];
   logic [RW-1:0]           run [N_LANES];
   logic [RW-1:0]           rn [N_LANES];
   logic [N_LANES-1:0]      nuevo;
   state_t                  st [N_LANES];
   paso_t                   nx [N_LANES];
   logic signed [CNT_W+1:0] suma;
   logic [CNT_W-1:0]        occ_n;

   // Each state accepts its own code (hold), one forward code and one backward code; anything else is illegal.
   function automatic paso_t mover(input state_t s, input logic [1:0] c, input logic [1:0] own,
                                   input logic [1:0] fc, input state_t fs, input logic [1:0] bc, input state_t bs);
      paso_t p;
      p.st  = c == own ? s : c == fc ? fs : c == bc ? bs : IDLE;
      p.err = c != own && c != fc && c != bc;
      p.ing = s == E3 && c == 2'b00;
      p.egr = s == X3 && c == 2'b00;
      return p;
   endfunction

   always_comb begin
      for (int i = 0; i < N_LANES; i++) begin
         rn[i] = s2[i] != prv[i] ? RW'(1) : run[i] == DEB ? run[i] : run[i] + RW'(1);
         case (st[i])
            E1:      nx[i] = mover(E1, stb[i], 2'b10, 2'b11, E2, 2'b00, IDLE);
            E2:      nx[i] = mover(E2, stb[i], 2'b11, 2'b01, E3, 2'b10, E1);
            E3:      nx[i] = mover(E3, stb[i], 2'b01, 2'b00, IDLE, 2'b11, E2);
            X1:      nx[i] = mover(X1, stb[i], 2'b01, 2'b11, X2, 2'b00, IDLE);
            X2:      nx[i] = mover(X2, stb[i], 2'b11, 2'b10, X3, 2'b01, X1);
            X3:      nx[i] = mover(X3, stb[i], 2'b10, 2'b00, IDLE, 2'b11, X2);
            default: nx[i] = mover(IDLE, stb[i], 2'b00, 2'b10, E1, 2'b01, X1);
         endcase
         // The FSM reacts once per newly accepted code, so a held illegal code errors only once.
         if (!nuevo[i]) nx[i] = '{st: st[i], ing: 1'b0, egr: 1'b0, err: 1'b0};
      end
   end

   always_comb begin
      suma = $signed({2'b00, ocupacion});
      for (int i = 0; i < N_LANES; i++)
         suma = suma + (nx[i].ing ? ONE : ZERO) - (nx[i].egr ? ONE : ZERO);
      occ_n = cargar ? (valor_carga > CAP_U ? CAP_U : valor_carga)
                     : suma[CNT_W+1] ? '0 : suma > CAP_S ? CAP_U : suma[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ocupacion <= '0;
         ingreso   <= '0;
         egreso    <= '0;
         error     <= '0;
         nuevo     <= '0;
         for (int i = 0; i < N_LANES; i++) begin
            s1[i]  <= 2'b00;
            s2[i]  <= 2'b00;
            prv[i] <= 2'b00;
            stb[i] <= 2'b00;
            run[i] <= '0;
            st[i]  <= IDLE;
         end
      end else begin
         ocupacion <= occ_n;
         for (int i = 0; i < N_LANES; i++) begin
            s1[i]      <= {a[i], b[i]};
            s2[i]      <= s1[i];
            prv[i]     <= s2[i];
            run[i]     <= rn[i];
            nuevo[i]   <= rn[i] >= DEB && s2[i] != stb[i];
            if (rn[i] >= DEB) stb[i] <= s2[i];
            st[i]      <= nx[i].st;
            ingreso[i] <= nx[i].ing;
            egreso[i]  <= nx[i].egr;
            error[i]   <= nx[i].err;
         end
      end
   end

   assign lleno = ocupacion == CAP_U;
   assign vacio = ocupacion == '0;
endmodule

// File: tb/tb_estacionamiento_multicarril.sv
// tb_estacionamiento_multicarril: directed and randomized checks against a path-position lane model
module tb_estacionamiento_multicarril;
   localparam int N = 2, CAP = 16, W = 5, DEB = 4, H = 10, LAT = DEB + 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         cargar = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic [W-1:0] valor_carga = '0;
   logic [N-1:0] ingreso, egreso, error;
   logic [W-1:0] ocupacion;
   logic         lleno, vacio;

   int checks = 0, errors = 0;
   int mdir[N], mpos[N], mocc;
   logic [1:0] macc[N];
   int exp_i[N], exp_e[N], exp_r[N], obs_i[N], obs_e[N], obs_r[N];
   int k, pulse_cyc, occ_before, occ_at, last_occ;
   logic vac_at, lle_at;
   logic [3*N-1:0] first_vec;

   estacionamiento_multicarril #(.N_LANES(N), .CAPACITY(CAP), .CNT_W(W), .DEB_CYCLES(DEB)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .cargar(cargar), .valor_carga(valor_carga),
      .ingreso(ingreso), .egreso(egreso), .error(error), .ocupacion(ocupacion),
      .lleno(lleno), .vacio(vacio)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
      for (int l = 0; l < N; l++) begin
         obs_i[l] += int'(ingreso[l]);
         obs_e[l] += int'(egreso[l]);
         obs_r[l] += int'(error[l]);
      end
      if ((ingreso | egreso | error) != '0 && pulse_cyc < 0) begin
         pulse_cyc  = k;
         first_vec  = {ingreso, egreso, error};
         occ_before = last_occ;
         occ_at     = int'(ocupacion);
         vac_at     = vacio;
         lle_at     = lleno;
      end
      last_occ = int'(ocupacion);
   endtask

   task automatic clr();
      k = 0;
      pulse_cyc = -1;
      first_vec = '0;
      for (int l = 0; l < N; l++) begin
         obs_i[l] = 0; obs_e[l] = 0; obs_r[l] = 0;
         exp_i[l] = 0; exp_e[l] = 0; exp_r[l] = 0;
      end
   endtask

   task automatic set_pins(input logic [1:0] c0, input logic [1:0] c1);
      a = {c1[1], c0[1]};
      b = {c1[0], c0[0]};
   endtask

   function automatic int clamp(input int v);
      return v < 0 ? 0 : v > CAP ? CAP : v;
   endfunction

   // Entry path is 00,10,11,01 and exit path 00,01,11,10; position p walks along it.
   function automatic logic [1:0] code_at(input int dir, input int p);
      logic [1:0] x;
      x = p == 0 ? 2'b00 : p == 1 ? 2'b10 : p == 2 ? 2'b11 : 2'b01;
      return dir == 2 ? {x[0], x[1]} : x;
   endfunction

   task automatic model_reset();
      for (int l = 0; l < N; l++) begin
         mdir[l] = 0; mpos[l] = 0; macc[l] = 2'b00;
      end
      mocc = 0;
   endtask

   task automatic model_lane(input int l, input logic [1:0] c);
      if (c == macc[l]) return;
      macc[l] = c;
      if (mdir[l] == 0) begin
         if (c == 2'b10 || c == 2'b01) begin
            mdir[l] = c == 2'b10 ? 1 : 2;
            mpos[l] = 1;
         end else if (c == 2'b11) exp_r[l] = 1;
      end else if (c == code_at(mdir[l], (mpos[l] + 1) % 4)) begin
         if (mpos[l] == 3) begin
            if (mdir[l] == 1) exp_i[l] = 1; else exp_e[l] = 1;
            mdir[l] = 0;
            mpos[l] = 0;
         end else mpos[l]++;
      end else if (c == code_at(mdir[l], mpos[l] - 1)) begin
         mpos[l]--;
         if (mpos[l] == 0) mdir[l] = 0;
      end else begin
         exp_r[l] = 1;
         mdir[l] = 0;
         mpos[l] = 0;
      end
   endtask

   function automatic logic [1:0] adv(input int l);
      if (mdir[l] == 0) return $urandom_range(1) == 1 ? 2'b10 : 2'b01;
      return code_at(mdir[l], (mpos[l] + 1) % 4);
   endfunction

   task automatic step(input logic [1:0] c0, input logic [1:0] c1);
      clr();
      model_lane(0, c0);
      model_lane(1, c1);
      mocc = clamp(mocc + exp_i[0] + exp_i[1] - exp_e[0] - exp_e[1]);
      set_pins(c0, c1);
      repeat (H) tick();
   endtask

   task automatic load(input int v);
      cargar = 1'b1;
      valor_carga = W'(v);
      tick();
      cargar = 1'b0;
      mocc = v > CAP ? CAP : v;
   endtask

   task automatic entry0();
      step(2'b10, 2'b00); step(2'b11, 2'b00); step(2'b01, 2'b00); step(2'b00, 2'b00);
   endtask

   task automatic exit1();
      step(2'b00, 2'b01); step(2'b00, 2'b11); step(2'b00, 2'b10); step(2'b00, 2'b00);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_pins(2'b00, 2'b00);
      repeat (3) tick();
      checks++; if ({ingreso, egreso, error} !== '0) begin errors++; $display("FAIL reset_pulses: got %b expected 0", {ingreso, egreso, error}); end
      checks++; if (ocupacion !== '0) begin errors++; $display("FAIL reset_ocupacion: got %0d expected 0", ocupacion); end
      checks++; if ({lleno, vacio} !== 2'b01) begin errors++; $display("FAIL reset_flags: got lleno=%b vacio=%b expected 0 1", lleno, vacio); end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_entry();
      entry0();
      checks++; if (obs_i[0] !== 1 || first_vec !== {2'b01, 2'b00, 2'b00}) begin errors++; $display("FAIL entry_pulse: got count=%0d vec=%b expected 1 and 010000", obs_i[0], first_vec); end
      checks++; if (pulse_cyc !== LAT) begin errors++; $display("FAIL entry_latency: got %0d expected %0d", pulse_cyc, LAT); end
      checks++; if (occ_before !== 0 || occ_at !== 1 || vac_at !== 1'b0) begin errors++; $display("FAIL entry_occ: got %0d->%0d vacio=%b expected 0->1 vacio=0", occ_before, occ_at, vac_at); end
   endtask

   task automatic test_exit();
      load(3);
      checks++; if (ocupacion !== W'(3)) begin errors++; $display("FAIL load_value: got %0d expected 3", ocupacion); end
      exit1();
      checks++; if (obs_e[1] !== 1 || obs_i[0] + obs_i[1] !== 0) begin errors++; $display("FAIL exit_pulse: got egreso=%0d ingreso=%0d expected 1 0", obs_e[1], obs_i[0] + obs_i[1]); end
      checks++; if (ocupacion !== W'(2)) begin errors++; $display("FAIL exit_occ: got %0d expected 2", ocupacion); end
   endtask

   task automatic test_glitch_abort();
      clr();
      set_pins(2'b10, 2'b00);
      repeat (2) tick();
      set_pins(2'b00, 2'b00);
      repeat (H) tick();
      checks++; if (obs_i[0] + obs_e[0] + obs_r[0] !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", obs_i[0] + obs_e[0] + obs_r[0]); end
      step(2'b10, 2'b00);
      step(2'b00, 2'b00);
      checks++; if (obs_i[0] + obs_e[0] + obs_r[0] !== 0) begin errors++; $display("FAIL abort_pulses: got %0d expected 0", obs_i[0] + obs_e[0] + obs_r[0]); end
      checks++; if (int'(ocupacion) !== mocc) begin errors++; $display("FAIL abort_occ: got %0d expected %0d", ocupacion, mocc); end
   endtask

   task automatic test_simultaneous();
      load(5);
      step(2'b10, 2'b01); step(2'b11, 2'b11); step(2'b01, 2'b10); step(2'b00, 2'b00);
      checks++; if (first_vec !== {2'b01, 2'b10, 2'b00} || pulse_cyc !== LAT) begin errors++; $display("FAIL simul_pulses: got %b at %0d expected 011000 at %0d", first_vec, pulse_cyc, LAT); end
      checks++; if (ocupacion !== W'(5)) begin errors++; $display("FAIL simul_occ: got %0d expected 5", ocupacion); end
   endtask

   task automatic test_full();
      load(15);
      entry0();
      checks++; if (ocupacion !== W'(16) || lleno !== 1'b1) begin errors++; $display("FAIL full_first: got %0d lleno=%b expected 16 1", ocupacion, lleno); end
      entry0();
      checks++; if (obs_i[0] !== 1) begin errors++; $display("FAIL full_pulse: got %0d expected 1", obs_i[0]); end
      checks++; if (ocupacion !== W'(16) || lleno !== 1'b1 || lle_at !== 1'b1) begin errors++; $display("FAIL full_sat: got %0d lleno=%b expected 16 1", ocupacion, lleno); end
   endtask

   task automatic test_empty();
      load(0);
      exit1();
      checks++; if (obs_e[1] !== 1) begin errors++; $display("FAIL empty_pulse: got %0d expected 1", obs_e[1]); end
      checks++; if (ocupacion !== '0 || vacio !== 1'b1) begin errors++; $display("FAIL empty_sat: got %0d vacio=%b expected 0 1", ocupacion, vacio); end
   endtask

   task automatic test_illegal();
      step(2'b00, 2'b11);
      checks++; if (obs_r[1] !== 1 || first_vec !== {2'b00, 2'b00, 2'b10}) begin errors++; $display("FAIL illegal_err: got count=%0d vec=%b expected 1 and 000010", obs_r[1], first_vec); end
      step(2'b00, 2'b00);
      checks++; if (obs_r[1] + obs_e[1] + obs_i[1] !== 0) begin errors++; $display("FAIL illegal_quiet: got %0d expected 0", obs_r[1] + obs_e[1] + obs_i[1]); end
      exit1();
      checks++; if (obs_e[1] !== 1 || obs_r[1] !== 0) begin errors++; $display("FAIL illegal_idle: got egreso=%0d error=%0d expected 1 0", obs_e[1], obs_r[1]); end
   endtask

   task automatic test_load_priority();
      load(4);
      step(2'b10, 2'b00); step(2'b11, 2'b00); step(2'b01, 2'b00);
      clr();
      model_lane(0, 2'b00);
      set_pins(2'b00, 2'b00);
      repeat (LAT - 1) tick();
      cargar = 1'b1;
      valor_carga = W'(20);
      tick();
      cargar = 1'b0;
      mocc = CAP;
      checks++; if (ingreso !== 2'b01 || exp_i[0] !== 1) begin errors++; $display("FAIL load_pulse: got %b expected 01", ingreso); end
      checks++; if (ocupacion !== W'(16)) begin errors++; $display("FAIL load_override: got %0d expected 16", ocupacion); end
      repeat (3) tick();
   endtask

   task automatic test_reset_mid();
      load(6);
      step(2'b10, 2'b00); step(2'b11, 2'b00);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      checks++; if ({ingreso, egreso, error} !== '0 || ocupacion !== '0 || {lleno, vacio} !== 2'b01) begin errors++; $display("FAIL midreset_outs: got %b occ=%0d flags=%b expected 0 0 01", {ingreso, egreso, error}, ocupacion, {lleno, vacio}); end
      step(2'b11, 2'b00);
      checks++; if (obs_r[0] !== exp_r[0] || obs_i[0] !== 0) begin errors++; $display("FAIL midreset_held: got err=%0d ing=%0d expected %0d 0", obs_r[0], obs_i[0], exp_r[0]); end
      step(2'b01, 2'b00);
      checks++; if (obs_i[0] !== 0) begin errors++; $display("FAIL midreset_01: got %0d expected 0", obs_i[0]); end
      step(2'b00, 2'b00);
      checks++; if (obs_i[0] !== 0 || ocupacion !== '0) begin errors++; $display("FAIL midreset_00: got ing=%0d occ=%0d expected 0 0", obs_i[0], ocupacion); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 80; n++) begin
         logic [1:0] c[N];
         if ($urandom_range(7) == 0) load(int'($urandom_range(31)));
         for (int l = 0; l < N; l++) c[l] = $urandom_range(9) < 7 ? adv(l) : 2'($urandom_range(3));
         step(c[0], c[1]);
         for (int l = 0; l < N; l++) begin
            checks++;
            if ({obs_i[l], obs_e[l], obs_r[l]} !== {exp_i[l], exp_e[l], exp_r[l]}) begin
               errors++;
               $display("FAIL rand_pulses lane%0d step%0d: got i/e/r=%0d/%0d/%0d expected %0d/%0d/%0d", l, n, obs_i[l], obs_e[l], obs_r[l], exp_i[l], exp_e[l], exp_r[l]);
            end
         end
         checks++;
         if (int'(ocupacion) !== mocc || lleno !== (mocc == CAP) || vacio !== (mocc == 0)) begin
            errors++;
            $display("FAIL rand_occ step%0d: got %0d lleno=%b vacio=%b expected %0d", n, ocupacion, lleno, vacio, mocc);
         end
      end
   endtask

   initial begin
      last_occ = 0;
      clr();
      test_reset();
      test_entry();
      test_exit();
      test_glitch_abort();
      test_simultaneous();
      test_full();
      test_empty();
      test_illegal();
      test_load_priority();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
